// File: rtl/dummy_mig_pipe.sv
// dummy_mig_pipe: queued MIG app_* stand-in with fixed read latency and byte masks.
// Define DMIG_RAND_STALL_EN to add LFSR-driven accept/pop stalls.
module dummy_mig_pipe #(
  parameter int DW         = 128,
  parameter int MW         = DW/8,
  parameter int AW         = 28,
  parameter int MEM_AW     = 10,
  parameter int ADDR_LSB   = 4,
  parameter int RD_LAT     = 15,
  parameter int CMDQ_DEPTH = 4
) (
  input  logic                        mclk,
  input  logic                        mrst,
  input  logic [AW-1:0]               app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [DW-1:0]               app_wdf_data,
  input  logic [MW-1:0]               app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [DW-1:0]               app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        cmd_err,
  output logic [$clog2(RD_LAT+1):0]   rd_inflight
);
  localparam int QW = $clog2(CMDQ_DEPTH);
  localparam int IW = $clog2(RD_LAT+1) + 1;
  logic [QW-1:0]     r_wp, r_rp;
  logic [QW:0]       r_cnt;
  logic              r_q_rd  [CMDQ_DEPTH];
  logic [MEM_AW-1:0] r_q_idx [CMDQ_DEPTH];
  logic [DW-1:0]     r_mem   [2**MEM_AW];
  logic [RD_LAT-1:0] r_pv;
  logic [DW-1:0]     r_pd    [RD_LAT];
  logic              w_stall, w_acc, w_legal, w_push, w_nempty, w_head_rd, w_pop, w_rd_pop;
  logic [MEM_AW-1:0] w_head_idx;
  logic              w_unused;
  assign w_unused = ^{app_wdf_end, app_addr};
`ifdef DMIG_RAND_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge mclk or posedge mrst)
    if (mrst) r_lfsr <= 16'hACE1;
    else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_stall = r_lfsr[1:0] == 2'b00;
`else
  assign w_stall = 1'b0;
`endif
  assign app_rdy     = !mrst & (r_cnt < (QW+1)'(CMDQ_DEPTH)) & !w_stall;
  assign w_acc       = app_en & app_rdy;
  assign w_legal     = app_cmd[2:1] == 2'b00;
  assign w_push      = w_acc & w_legal;
  assign w_nempty    = r_cnt != '0;
  assign w_head_rd   = r_q_rd[r_rp];
  assign w_head_idx  = r_q_idx[r_rp];
  assign app_wdf_rdy = w_nempty & !w_head_rd & !w_stall;
  assign w_pop       = w_nempty & !w_stall & (w_head_rd | app_wdf_wren);
  assign w_rd_pop    = w_pop & w_head_rd;
  always_ff @(posedge mclk or posedge mrst)
    if (mrst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      cmd_err     <= 1'b0;
      rd_inflight <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt       <= r_cnt + (QW+1)'(w_push) - (QW+1)'(w_pop);
      if (w_acc & !w_legal) cmd_err <= 1'b1;
      rd_inflight <= rd_inflight + IW'(w_rd_pop) - IW'(app_rd_data_valid);
    end
  // Queue storage and memory are never reset; memory survives mrst.
  always_ff @(posedge mclk) begin
    if (w_push) begin
      r_q_rd[r_wp]  <= app_cmd[0];
      r_q_idx[r_wp] <= app_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB];
    end
    if (w_pop & !w_head_rd)
      for (int b = 0; b < MW; b++)
        if (!app_wdf_mask[b]) r_mem[w_head_idx][b*8 +: 8] <= app_wdf_data[b*8 +: 8];
  end
  // Data stages only move with their valid bit, so the last stage holds between beats.
  always_ff @(posedge mclk or posedge mrst)
    if (mrst) begin
      r_pv <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pd[k] <= '0;
    end else begin
      r_pv[0] <= w_rd_pop;
      if (w_rd_pop) r_pd[0] <= r_mem[w_head_idx];
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) r_pd[k] <= r_pd[k-1];
      end
    end
  assign app_rd_data       = r_pd[RD_LAT-1];
  assign app_rd_data_valid = r_pv[RD_LAT-1];
  assign app_rd_data_end   = r_pv[RD_LAT-1];
endmodule

// File: tb/tb_dummy_mig_pipe.sv
// tb_dummy_mig_pipe: directed vector table plus hand-written multi-cycle sequences for dummy_mig_pipe.
module tb_dummy_mig_pipe;
  localparam logic [127:0] D1 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] W4 = 128'h55AA55AA_00FF00FF_F0F0F0F0_12345678;
  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } vec_t;
  logic         mclk = 1'b0, mrst = 1'b1;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0, app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0, app_wdf_end = 1'b1, app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid, app_rd_data_end, cmd_err;
  logic [4:0]   rd_inflight;
  int           n_chk = 0, n_fail = 0, stalls = 0;
  vec_t         tbl[16];
  logic [127:0] sb[16];
  logic [127:0] b2b[4];
  dummy_mig_pipe dut (
    .mclk(mclk), .mrst(mrst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .cmd_err(cmd_err), .rd_inflight(rd_inflight)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask
  task automatic issue(input logic [2:0] cmd, input logic [27:0] addr);
    bit r, acc;
    acc = 0;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    for (int n = 0; n < 200; n++) begin
      r = app_rdy;
      if (!r) stalls++;
      tick();
      if (r) begin acc = 1; break; end
    end
    app_en = 1'b0;
    if (!acc) chk("cmd_accept", acc, 1);
  endtask
  task automatic wdata(input logic [127:0] d, input logic [15:0] m);
    bit r, acc;
    acc = 0;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    for (int n = 0; n < 200; n++) begin
      r = app_wdf_rdy;
      tick();
      if (r) begin acc = 1; break; end
    end
    app_wdf_wren = 1'b0;
    if (!acc) chk("wdf_accept", acc, 1);
  endtask
  task automatic wait_rd(output logic [127:0] d, output int edges, output bit got);
    got = 0; d = '0; edges = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      edges = n + 1;
      if (app_rd_data_valid) begin
        got = 1; d = app_rd_data;
        chk("rd_end", app_rd_data_end, 1);
        break;
      end
    end
  endtask
  task automatic count_beats(input int cycles, input logic [127:0] exp, output int beats);
    beats = 0;
    for (int c = 0; c < cycles; c++) begin
      if (app_rd_data_valid) begin
        chk("beat_data", app_rd_data, exp);
        beats++;
      end
      tick();
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [127:0] d, wd;
    logic [15:0]  m;
    int edges, beats, first, last, peak, k, idx;
    bit got, r;
    tbl = '{
      '{1'b1, 28'h0000050, D1, 16'h0000},
      '{1'b0, 28'h0000050, D1, 16'h0000},
      '{1'b1, 28'h0000070, {128{1'b1}}, 16'h0000},
      '{1'b1, 28'h0000070, 128'h0, 16'hFF00},
      '{1'b0, 28'h0000070, {{64{1'b1}}, 64'h0}, 16'h0000},
      '{1'b1, 28'h0000090, 128'h0, 16'h0000},
      '{1'b1, 28'h0000090, {8{16'h1111}}, 16'hAAAA},
      '{1'b0, 28'h0000090, {8{16'h0011}}, 16'h0000},
      '{1'b1, 28'h0004030, D3, 16'h0000},
      '{1'b0, 28'h0000030, D3, 16'h0000},
      '{1'b1, 28'h0000050, 128'h0, 16'hFFFF},
      '{1'b0, 28'h0000050, D1, 16'h0000},
      '{1'b1, 28'h0000000, 128'hA0, 16'h0000},
      '{1'b1, 28'h0000010, 128'hA1, 16'h0000},
      '{1'b1, 28'h0000020, 128'hA2, 16'h0000},
      '{1'b0, 28'hABC0020, 128'hA2, 16'h0000}
    };
    b2b = '{128'hA0, 128'hA1, 128'hA2, D3};
    repeat (3) tick();
    chk("rst_app_rdy", app_rdy, 0);
    chk("rst_wdf_rdy", app_wdf_rdy, 0);
    chk("rst_valid", app_rd_data_valid, 0);
    chk("rst_rd_data", app_rd_data, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_inflight", rd_inflight, 0);
    mrst = 1'b0;
    tick();
    chk("post_rst_app_rdy", app_rdy, 1);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        issue(3'b000, tbl[i].addr);
        wdata(tbl[i].data, tbl[i].mask);
      end else begin
        issue(3'b001, tbl[i].addr);
        wait_rd(d, edges, got);
        chk("tbl_rd_got", got, 1);
        chk("tbl_rd_data", d, tbl[i].data);
`ifndef DMIG_RAND_STALL_EN
        chk("tbl_rd_latency", edges, 15);
`endif
      end
    end
    chk("tbl_cmd_err", cmd_err, 0);
    app_en = 1'b1; app_cmd = 3'b001;
    for (int i = 0; i < 4; i++) begin
      app_addr = 28'(i << 4);
      chk("b2b_app_rdy", app_rdy, 1);
      tick();
    end
    app_en = 1'b0;
    beats = 0; first = -1; last = -1; peak = 0;
    for (int c = 0; c < 60; c++) begin
      if (int'(rd_inflight) > peak) peak = int'(rd_inflight);
      if (app_rd_data_valid) begin
        if (beats < 4) chk("b2b_data", app_rd_data, b2b[beats]);
        if (beats == 0) first = c;
        last = c;
        beats++;
      end
      tick();
    end
    chk("b2b_beats", beats, 4);
    chk("b2b_contiguous", last - first, 3);
    chk("b2b_peak_inflight", peak, 4);
    chk("b2b_final_inflight", rd_inflight, 0);
    k = 0;
    app_en = 1'b1; app_addr = 28'h00000A0;
    for (int c = 0; c < 6; c++) begin
      app_cmd = (k == 0) ? 3'b000 : 3'b001;
      r = app_rdy;
      tick();
      if (r) k++;
    end
    chk("full_accepts", k, 4);
    chk("full_app_rdy", app_rdy, 0);
    chk("full_wdf_rdy", app_wdf_rdy, 1);
    app_wdf_wren = 1'b1; app_wdf_data = W4; app_wdf_mask = 16'h0;
    chk("full_no_bypass", app_rdy, 0);
    tick();
    app_wdf_wren = 1'b0;
    chk("drain_app_rdy", app_rdy, 1);
    tick();
    app_en = 1'b0;
    count_beats(60, W4, beats);
    chk("full_beats", beats, 4);
    app_en = 1'b1; app_cmd = 3'b011;
    chk("ill_app_rdy", app_rdy, 1);
    tick();
    app_en = 1'b0; app_cmd = 3'b000;
    chk("ill_cmd_err", cmd_err, 1);
    chk("ill_queue_empty", app_wdf_rdy, 0);
    count_beats(20, 128'h0, beats);
    chk("ill_no_beats", beats, 0);
    chk("ill_err_sticky", cmd_err, 1);
    chk("ill_inflight", rd_inflight, 0);
    issue(3'b001, 28'h0000050);
    repeat (5) tick();
    chk("mid_inflight", rd_inflight, 1);
    #2 mrst = 1'b1;
    #1;
    chk("arst_cmd_err", cmd_err, 0);
    chk("arst_inflight", rd_inflight, 0);
    chk("arst_app_rdy", app_rdy, 0);
    chk("arst_rd_data", app_rd_data, 0);
    tick(); tick();
    mrst = 1'b0;
    count_beats(30, 128'h0, beats);
    chk("arst_no_beats", beats, 0);
    issue(3'b001, 28'h0000050);
    wait_rd(d, edges, got);
    chk("retain_got", got, 1);
    chk("retain_data", d, D1);
    for (int i = 0; i < 16; i++) begin
      sb[i] = {$urandom, $urandom, $urandom, $urandom};
      issue(3'b000, 28'((32 + i) << 4));
      wdata(sb[i], 16'h0);
    end
    for (int p = 0; p < 64; p++) begin
      idx = $urandom_range(0, 15);
      wd = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom_range(0, 16'hFFFF));
      issue(3'b000, 28'((32 + idx) << 4));
      wdata(wd, m);
      for (int b = 0; b < 16; b++)
        if (!m[b]) sb[idx][b*8 +: 8] = wd[b*8 +: 8];
      issue(3'b001, 28'((32 + idx) << 4));
      wait_rd(d, edges, got);
      chk("rand_got", got, 1);
      chk("rand_data", d, sb[idx]);
    end
`ifdef DMIG_RAND_STALL_EN
    chk("rand_stalls_seen", stalls > 0, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dummy_mig_pipe.md
Name: dummy_mig_pipe

Overview:
Parametrised simulation-only stand-in for the MIG DDR user interface (app_* ports).
- Successor to the single-outstanding dummy model: queues up to CMDQ_DEPTH commands, pipelines reads at a fixed programmable latency, and honours write byte masks.
- Sits behind the AXI-to-MIG bridge in the sim testbench and replaces the real MIG + DDR model.

Parameters:
DW, 128, data width of app_wdf_data / app_rd_data (multiple of 8)
MW, DW/8, byte-mask width
AW, 28, app_addr width
MEM_AW, 10, memory word-address bits (2^MEM_AW words of DW bits)
ADDR_LSB, 4, app_addr bit where the word index starts (log2(DW/8))
RD_LAT, 15, cycles from read issue to app_rd_data_valid (>=1)
CMDQ_DEPTH, 4, command queue entries (power of 2, >=2)

Ports:
mclk  in  1  clock
mrst  in  1  asynchronous active-high reset
app_addr  in  AW  command address
app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
app_en  in  1  command valid
app_rdy  out  1  command accept
app_wdf_data  in  DW  write data
app_wdf_mask  in  MW  byte mask, 1 = byte NOT written
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat (always 1, single-beat)
app_wdf_rdy  out  1  write data accept
app_rd_data  out  DW  read data
app_rd_data_valid  out  1  read data valid
app_rd_data_end  out  1  equals app_rd_data_valid
cmd_err  out  1  sticky illegal-command flag
rd_inflight  out  $clog2(RD_LAT+1)+1  reads currently in latency pipe

Behaviour:
- Reset (mrst high, async): queue empty, latency pipe cleared, app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data=0, cmd_err=0, rd_inflight=0. Memory array contents are not cleared. Reset mid-operation drops all queued/in-flight commands with no further output.
- Accept: command taken when app_en & app_rdy. app_rdy = !mrst & (count < CMDQ_DEPTH). Each entry stores {cmd[0], word index = app_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB]}. Upper address bits are ignored, so addresses alias.
- Illegal app_cmd (not 000/001): accepted, not queued, sets cmd_err until reset.
- Head engine processes the queue strictly in order, one entry per cycle at most:
  - HEAD_WR: app_wdf_rdy = queue non-empty & head is write. On app_wdf_wren & app_wdf_rdy: for each byte b with mask[b]=0, mem[idx] byte b <= data byte b, then pop. Masked bytes keep their old value.
  - HEAD_RD: pop immediately. mem[idx] is sampled in the pop cycle (sees all earlier writes, none later) and the sample enters an RD_LAT-stage shift pipe.
- Read output: app_rd_data_valid/app_rd_data_end pulse exactly RD_LAT cycles after the pop cycle. A read popped at edge N is valid in the cycle after edge N+RD_LAT-1. Back-to-back reads produce back-to-back valid beats, one per read, in order. app_rd_data holds its last value while valid is low.
- No backpressure on read data; the consumer must always accept.
- Enqueue and pop in the same cycle are allowed; count is unchanged. When full, app_rdy is low even if a pop occurs that cycle (no bypass).
- app_wdf_wren while app_wdf_rdy=0 is ignored (no data FIFO).
- rd_inflight increments on a read pop and decrements on a valid beat. Both in the same cycle leave it unchanged.

Optional Feature:
DMIG_RAND_STALL_EN
- Defined: a 16-bit LFSR (seed 16'hACE1, reset to seed, taps x^16+x^14+x^13+x^11+1) advances every cycle. When lfsr[1:0]==2'b00, app_rdy and app_wdf_rdy are forced low and no pop occurs that cycle. Read latency for already-popped reads is unaffected.
- Undefined: no stalls; behaviour exactly as above.

Test Plan:
1. Write idx 5 data 128'h0123..EF, mask 16'h0000, then read idx 5 -> one valid beat 15 cycles after read pop, data matches, cmd_err=0.
2. Pre-fill idx 7 with all-FF, write 128'h0 with mask 16'hFF00 -> read returns 128'hFFFF..FF_0000..00: upper 8 bytes FF, lower 8 bytes 00.
3. Four reads to idx 0..3 issued back-to-back -> app_rdy never drops. Four consecutive valid beats in order. rd_inflight peaks at 4 and returns to 0.
4. Hold app_wdf_wren low with head=write, issue 4 more commands -> app_rdy=0 once count=4. The first wren drains one entry; app_rdy returns 1 the next cycle.
5. app_cmd=3'b011 -> cmd_err=1 and stays high, queue count unchanged. Assert mrst mid-read -> valid never fires, cmd_err=0, memory retains idx 5 data.
6. DMIG_RAND_STALL_EN defined, 64 random write/read pairs -> all read data match the scoreboard and app_rdy shows stall cycles.
